// File: rtl/cart_freeze_ctrl_if.sv
// Request/status bundle between the input/OSD logic, the cart and the freeze sequencer.
// The sequencer takes the slave side; whoever drives requests takes the master side.
interface cart_freeze_ctrl_if;
    logic       enable;
    logic       btn_freeze;
    logic       osd_freeze;
    logic       kbd_freeze;
    logic       cart_int7;
    logic       err_clr;
    logic       freeze;
    logic       busy;
    logic [1:0] grant_src;
    logic       timeout_err;
    logic       drop_err;

    modport slave (
        input  enable, btn_freeze, osd_freeze, kbd_freeze, cart_int7, err_clr,
        output freeze, busy, grant_src, timeout_err, drop_err
    );

    modport master (
        output enable, btn_freeze, osd_freeze, kbd_freeze, cart_int7, err_clr,
        input  freeze, busy, grant_src, timeout_err, drop_err
    );
endinterface

// File: rtl/cart_freeze_ctrl.sv
// Freeze (level-7 NMI) entry sequencer for the HRTmon cart: arbitrates OSD, hotkey and
// debounced button requests, pulses freeze, waits for the int7 handshake, then holds off.
module cart_freeze_ctrl #(
    parameter logic [15:0] DEB_TICKS     = 16'd7000,
    parameter logic [3:0]  PULSE_TICKS   = 4'd2,
    parameter logic [23:0] TIMEOUT_TICKS = 24'd7000000,
    parameter logic [19:0] HOLDOFF_TICKS = 20'd70000
) (
    input logic               clk,
    input logic               _rst,
    input logic               clk7_en,
    input logic               cpu_rst,
    cart_freeze_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ASSERT   = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;
    localparam logic [1:0] ST_HOLDOFF  = 2'd3;

    localparam logic [15:0] DEB_LAST     = DEB_TICKS - 16'd1;
    localparam logic [23:0] PULSE_LAST   = {20'd0, PULSE_TICKS} - 24'd1;
    localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_TICKS - 24'd1;
    localparam logic [23:0] HOLDOFF_LAST = {4'd0, HOLDOFF_TICKS} - 24'd1;

    // Button synchroniser, advanced only on clk7_en ticks
    logic [1:0] sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic stage_in;
            if (gi == 0) begin : g_first
                assign stage_in = bus.btn_freeze;
            end else begin : g_next
                assign stage_in = sync_reg[gi-1];
            end

            always_ff @(posedge clk or negedge _rst) begin
                if (!_rst) begin
                    sync_reg[gi] <= 1'b0;
                end else if (clk7_en) begin
                    sync_reg[gi] <= stage_in;
                end
            end
        end
    endgenerate

    logic [15:0] deb_cnt_reg, deb_cnt_next;
    logic        deb_level_reg, deb_level_next;
    logic        btn_req_reg, btn_req_next;

    // Counter restarts whenever the synced input agrees with the debounced level
    always_comb begin
        deb_cnt_next   = deb_cnt_reg;
        deb_level_next = deb_level_reg;
        btn_req_next   = btn_req_reg;
        if (clk7_en) begin
            if (sync_reg[1] == deb_level_reg) begin
                deb_cnt_next = 16'd0;
            end else if (deb_cnt_reg >= DEB_LAST) begin
                deb_level_next = sync_reg[1];
                deb_cnt_next   = 16'd0;
            end else begin
                deb_cnt_next = deb_cnt_reg + 16'd1;
            end
            btn_req_next = deb_level_next & ~deb_level_reg;
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            deb_cnt_reg   <= 16'd0;
            deb_level_reg <= 1'b0;
            btn_req_reg   <= 1'b0;
        end else begin
            deb_cnt_reg   <= deb_cnt_next;
            deb_level_reg <= deb_level_next;
            btn_req_reg   <= btn_req_next;
        end
    end

    logic [2:0]  req;
    logic [1:0]  state_reg, state_next;
    logic [23:0] cnt_reg, cnt_next, cnt_inc;
    logic        seen_hi_reg, seen_hi_next;
    logic        freeze_reg, freeze_next;
    logic [1:0]  grant_src_reg, grant_src_next;
    logic        timeout_err_reg, timeout_err_next;
    logic        drop_err_reg, drop_err_next;
    logic        timeout_set, drop_set;

    assign req     = {bus.osd_freeze, bus.kbd_freeze, btn_req_reg};
    assign cnt_inc = (cnt_reg == 24'hFF_FFFF) ? cnt_reg : cnt_reg + 24'd1;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        seen_hi_next   = seen_hi_reg;
        freeze_next    = freeze_reg;
        grant_src_next = grant_src_reg;
        timeout_set    = 1'b0;
        drop_set       = 1'b0;
        if (clk7_en) begin
            drop_set = (state_reg != ST_IDLE) && (|req);
            if (cpu_rst) begin
                state_next   = ST_IDLE;
                freeze_next  = 1'b0;
                cnt_next     = 24'd0;
                seen_hi_next = 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (bus.enable && (|req)) begin
                            grant_src_next = req[2] ? 2'd1 : (req[1] ? 2'd2 : 2'd3);
                            freeze_next    = 1'b1;
                            cnt_next       = 24'd0;
                            state_next     = ST_ASSERT;
                        end
                    end
                    ST_ASSERT: begin
                        if (cnt_reg >= PULSE_LAST) begin
                            freeze_next  = 1'b0;
                            cnt_next     = 24'd0;
                            seen_hi_next = 1'b0;
                            state_next   = ST_WAIT_ACK;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end
                    ST_WAIT_ACK: begin
                        // Ack is tested first so it beats a coincident timeout
                        if (seen_hi_reg && !bus.cart_int7) begin
                            cnt_next   = 24'd0;
                            state_next = ST_HOLDOFF;
                        end else if (cnt_reg >= TIMEOUT_LAST) begin
                            cnt_next    = 24'd0;
                            timeout_set = 1'b1;
                            state_next  = ST_HOLDOFF;
                        end else begin
                            cnt_next = cnt_inc;
                            if (bus.cart_int7) begin
                                seen_hi_next = 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (cnt_reg >= HOLDOFF_LAST) begin
                            cnt_next   = 24'd0;
                            state_next = ST_IDLE;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end
                endcase
            end
        end
    end

    // Sticky flags: a set on the same tick as err_clr survives
    always_comb begin
        timeout_err_next = timeout_err_reg;
        drop_err_next    = drop_err_reg;
        if (clk7_en) begin
            timeout_err_next = timeout_set | (timeout_err_reg & ~bus.err_clr);
            drop_err_next    = drop_set | (drop_err_reg & ~bus.err_clr);
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= 24'd0;
            seen_hi_reg     <= 1'b0;
            freeze_reg      <= 1'b0;
            grant_src_reg   <= 2'd0;
            timeout_err_reg <= 1'b0;
            drop_err_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            seen_hi_reg     <= seen_hi_next;
            freeze_reg      <= freeze_next;
            grant_src_reg   <= grant_src_next;
            timeout_err_reg <= timeout_err_next;
            drop_err_reg    <= drop_err_next;
        end
    end

    assign bus.freeze      = freeze_reg;
    assign bus.busy        = (state_reg != ST_IDLE);
    assign bus.grant_src   = grant_src_reg;
    assign bus.timeout_err = timeout_err_reg;
    assign bus.drop_err    = drop_err_reg;

endmodule
